// File: rtl/multi_pet_feeder_pkg.sv
// Shared definitions for the multi-bowl pet feeder.
//   option_e   : keypad command codes
//   ch_state_e : per-channel feeding state
//   ch_cmd_t   : decoded, already-validated command strobes for one channel
//   ch_idx_w() : width of a channel index (at least 1 bit, even for one channel)
package multi_pet_feeder_pkg;

  typedef enum logic [2:0] {
    OPT_IDLE      = 3'd0,
    OPT_POUR_FOOD = 3'd1,
    OPT_STOP_FOOD = 3'd2,
    OPT_INTERVAL  = 3'd3,
    OPT_RESET     = 3'd4
  } option_e;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_POUR = 2'd1,
    CH_WAIT = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic pour;      // one-shot portion
    logic interval;  // latch interval and start periodic feeding
    logic stop;      // park in IDLE, keep interval
    logic reset;     // park in IDLE, clear interval and portion count
  } ch_cmd_t;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_pet_feeder_if.sv
// Keypad bus of the feeder: command code, target channel, command strobe,
// decimal digit and digit strobe.
//   master : keypad side (drives everything)
//   slave  : feeder side (samples everything)
interface multi_pet_feeder_if #(
  parameter int CHANNELS = 2
);
  import multi_pet_feeder_pkg::*;

  localparam int CH_W = ch_idx_w(CHANNELS);

  logic [2:0]      keyboard_option;
  logic [CH_W-1:0] keyboard_channel;
  logic            option_enable;
  logic [3:0]      keyboard_digit;
  logic            digit_enable;

  modport master (
    output keyboard_option, keyboard_channel, option_enable,
    output keyboard_digit, digit_enable
  );

  modport slave (
    input keyboard_option, keyboard_channel, option_enable,
    input keyboard_digit, digit_enable
  );

endinterface

// File: rtl/multi_pet_feeder_channel.sv
// feeder_channel: one bowl. IDLE/POUR/WAIT state machine with a pour-tick
// counter, a wait-tick counter and the channel's interval register.
// Optional feature macro: FEEDER_PORTION_LIMIT_EN (portion cap per channel).
// Ports:
//   clk, rst_n     clock / async active-low reset
//   tick_i         shared timing strobe
//   cmd_i          validated command strobes addressed to this channel
//   interval_i     keypad entry value, latched on an interval command
//   food_switch_o  dispenser on while pouring
//   at_limit_o     portion cap reached (always 0 without the feature)
module feeder_channel
  import multi_pet_feeder_pkg::*;
#(
  parameter int POUR_TICKS   = 5,
  parameter int INTERVAL_W   = 16,
  parameter int MAX_PORTIONS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  ch_cmd_t               cmd_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  output logic                  food_switch_o,
  output logic                  at_limit_o
);

  localparam int PW = (POUR_TICKS > 1) ? $clog2(POUR_TICKS) : 1;
  localparam logic [PW-1:0] POUR_LAST = PW'(POUR_TICKS - 1);

  ch_state_e             state_q, state_d;
  logic [PW-1:0]         pour_cnt_q, pour_cnt_d;
  logic [INTERVAL_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic                  periodic_q, periodic_d;
  logic                  pour_entry;
  logic                  limit_hit;

`ifdef FEEDER_PORTION_LIMIT_EN
  localparam int PCW = $clog2(MAX_PORTIONS + 1);
  logic [PCW-1:0] portions_q;

  assign limit_hit = (portions_q == PCW'(MAX_PORTIONS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            portions_q <= '0;
    else if (cmd_i.reset)  portions_q <= '0;
    else if (pour_entry)   portions_q <= portions_q + PCW'(1);
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign at_limit_o    = limit_hit;
  assign food_switch_o = (state_q == CH_POUR);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CH_IDLE;
      pour_cnt_q <= '0;
      wait_cnt_q <= '0;
      interval_q <= '0;
      periodic_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pour_cnt_q <= pour_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      interval_q <= interval_d;
      periodic_q <= periodic_d;
    end
  end

  // Commands take priority over the tick, so a tick arriving together with a
  // command is dropped for this channel.
  always_comb begin
    // NOTE: every output gets its hold value first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d    = state_q;
    pour_cnt_d = pour_cnt_q;
    wait_cnt_d = wait_cnt_q;
    interval_d = interval_q;
    periodic_d = periodic_q;
    pour_entry = 1'b0;

    if (cmd_i.reset) begin
      state_d    = CH_IDLE;
      pour_cnt_d = '0;
      wait_cnt_d = '0;
      interval_d = '0;
      periodic_d = 1'b0;
    end else if (cmd_i.stop) begin
      state_d    = CH_IDLE;
      pour_cnt_d = '0;
      wait_cnt_d = '0;
      periodic_d = 1'b0;
    end else if (cmd_i.pour) begin
      state_d    = CH_POUR;
      pour_cnt_d = '0;
      wait_cnt_d = '0;
      periodic_d = 1'b0;
      pour_entry = 1'b1;
    end else if (cmd_i.interval) begin
      state_d    = CH_POUR;
      pour_cnt_d = '0;
      wait_cnt_d = '0;
      interval_d = interval_i;
      periodic_d = 1'b1;
      pour_entry = 1'b1;
    end else if (tick_i) begin
      unique case (state_q)
        CH_POUR: begin
          if (pour_cnt_q == POUR_LAST) begin
            pour_cnt_d = '0;
            state_d    = periodic_q ? CH_WAIT : CH_IDLE;
          end else begin
            pour_cnt_d = pour_cnt_q + PW'(1);
          end
        end
        CH_WAIT: begin
          // interval_q is never 0 here: a zero interval is rejected upstream.
          if (wait_cnt_q == interval_q - INTERVAL_W'(1)) begin
            wait_cnt_d = '0;
            if (limit_hit) begin
              state_d    = CH_IDLE;
              periodic_d = 1'b0;
            end else begin
              state_d    = CH_POUR;
              pour_entry = 1'b1;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + INTERVAL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_pet_feeder.sv
// multi_pet_feeder: keypad front end plus CHANNELS independent bowl channels.
// Holds the command-strobe edge detector, command decoder/validator, decimal
// entry accumulator and the cmd_error pulse.
// Optional feature macro: FEEDER_PORTION_LIMIT_EN (per-channel portion cap).
// Ports:
//   clk, rst_n     clock / async active-low reset
//   tick_i         1-cycle timing strobe shared by all channels
//   kp             keypad bus (slave side)
//   food_switch_o  per-channel dispenser on
//   cmd_error_o    1-cycle pulse on a rejected command
//   entry_value_o  current accumulated keypad value
module multi_pet_feeder
  import multi_pet_feeder_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int POUR_TICKS   = 5,
  parameter int INTERVAL_W   = 16,
  parameter int MAX_PORTIONS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  multi_pet_feeder_if.slave     kp,
  output logic [CHANNELS-1:0]   food_switch_o,
  output logic                  cmd_error_o,
  output logic [INTERVAL_W-1:0] entry_value_o
);

  localparam int CH_W = ch_idx_w(CHANNELS);
  localparam int EW   = INTERVAL_W + 4;
  localparam logic [INTERVAL_W-1:0] ENTRY_MAX = '1;

  logic                  opt_en_prev_q;
  logic                  cmd_valid_q;
  logic [2:0]            cmd_code_q;
  logic [CH_W-1:0]       cmd_ch_q;
  logic                  cmd_error_q;
  logic [INTERVAL_W-1:0] entry_q, entry_d;

  logic [CHANNELS-1:0]   at_limit;
  logic                  ch_ok, code_ok, sel_limit, reject, accept, clear_entry;
  logic [INTERVAL_W-1:0] entry_base;
  logic [EW-1:0]         entry_prod;

  // Command fields are captured on the 0->1 edge of option_enable and acted
  // on in the following cycle; holding the strobe high issues nothing more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opt_en_prev_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      cmd_ch_q      <= '0;
      cmd_error_q   <= 1'b0;
      entry_q       <= '0;
    end else begin
      opt_en_prev_q <= kp.option_enable;
      cmd_valid_q   <= kp.option_enable & ~opt_en_prev_q;
      if (kp.option_enable & ~opt_en_prev_q) begin
        cmd_code_q <= kp.keyboard_option;
        cmd_ch_q   <= kp.keyboard_channel;
      end
      cmd_error_q   <= reject;
      entry_q       <= entry_d;
    end
  end

  always_comb begin
    ch_ok     = 32'(cmd_ch_q) < 32'(CHANNELS);
    code_ok   = cmd_code_q <= 3'(OPT_RESET);
    sel_limit = ch_ok ? at_limit[cmd_ch_q] : 1'b0;
    reject    = cmd_valid_q &
                (~code_ok | ~ch_ok |
                 ((cmd_code_q == OPT_INTERVAL) && (entry_q == '0)) |
                 (((cmd_code_q == OPT_POUR_FOOD) || (cmd_code_q == OPT_INTERVAL)) && sel_limit));
    accept      = cmd_valid_q & ~reject;
    clear_entry = accept & ((cmd_code_q == OPT_INTERVAL) || (cmd_code_q == OPT_RESET));
  end

  // A digit arriving with an entry-clearing command starts the new entry.
  always_comb begin
    entry_base = clear_entry ? '0 : entry_q;
    entry_prod = {4'b0, entry_base} * EW'(10) + EW'(kp.keyboard_digit);
    entry_d    = entry_base;
    if (kp.digit_enable && (kp.keyboard_digit <= 4'd9))
      entry_d = (entry_prod > EW'(ENTRY_MAX)) ? ENTRY_MAX : entry_prod[INTERVAL_W-1:0];
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ch_cmd_t cmd;

    always_comb begin
      cmd = '0;
      if (accept && (cmd_ch_q == CH_W'(i))) begin
        cmd.pour     = (cmd_code_q == OPT_POUR_FOOD);
        cmd.stop     = (cmd_code_q == OPT_STOP_FOOD);
        cmd.interval = (cmd_code_q == OPT_INTERVAL);
        cmd.reset    = (cmd_code_q == OPT_RESET);
      end
    end

    feeder_channel #(
      .POUR_TICKS   (POUR_TICKS),
      .INTERVAL_W   (INTERVAL_W),
      .MAX_PORTIONS (MAX_PORTIONS)
    ) u_channel (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick_i        (tick_i),
      .cmd_i         (cmd),
      .interval_i    (entry_q),
      .food_switch_o (food_switch_o[i]),
      .at_limit_o    (at_limit[i])
    );
  end

  assign cmd_error_o   = cmd_error_q;
  assign entry_value_o = entry_q;

endmodule
